if_prefetch: RTL and testbench

//  Instruction-fetch stage ahead of the pipelined datapath's IF/ID register. Generates sequential
//  PCs, issues pipelined reads to instruction memory and buffers {pc, instr} pairs in a small

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/if_prefetch.sv | 85 ++++++++
 tb/tb_if_prefetch.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: the canonical NOP encoding and the {pc, instr} queue entry.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two queue of fetch entries with synchronous clear and combinational head.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !clear;
  // Pop on an empty queue is silently ignored.
  assign do_pop  = pop && !clear && (count_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

  // The issue-side credit scheme must make this unreachable.
  push_when_full : assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: credit-limited pipelined imem reads feeding a {pc, instr} queue,
// with flush-driven redirect that discards responses still in flight.
module if_prefetch
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUT) + 1;

  logic [31:0]   fetch_pc_q, resp_pc_q;
  logic [OW-1:0] out_cnt_q, drop_cnt_q;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_data;
  logic          issue, keep, drop, pop;
  logic [31:0]   inflight;

  // Credit: queued plus outstanding never exceeds the queue depth, so every response fits.
  assign inflight  = 32'(count) + 32'(out_cnt_q);
  assign imem_req  = !reset && !flush && (inflight < DEPTH) && (32'(out_cnt_q) < MAX_OUT);
  assign imem_addr = fetch_pc_q;

  assign issue = imem_req && imem_gnt;
  assign keep  = imem_rvalid && (drop_cnt_q == '0) && !flush;
  assign drop  = imem_rvalid && (drop_cnt_q != '0);
  assign pop   = if_valid && id_ready && !flush;

  assign push_data.pc    = resp_pc_q;
  assign push_data.instr = imem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (flush) begin
      // Everything still outstanding after this cycle is stale and must be discarded.
      fetch_pc_q <= flush_pc;
      resp_pc_q  <= flush_pc;
      out_cnt_q  <= out_cnt_q - OW'(imem_rvalid);
      drop_cnt_q <= out_cnt_q - OW'(imem_rvalid);
    end else begin
      if (issue) fetch_pc_q <= fetch_pc_q + 32'd4;
      if (keep)  resp_pc_q  <= resp_pc_q + 32'd4;
      out_cnt_q <= out_cnt_q + OW'(issue) - OW'(imem_rvalid);
      if (drop) drop_cnt_q <= drop_cnt_q - OW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (keep),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? head.pc : 32'h0;
  assign if_instr = if_valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch; memory returns {16'hC0DE, addr[15:0]} in request order.
module tb_if_prefetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        flush;
  logic [31:0] flush_pc;

  logic [31:0] mq[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  if_prefetch #(
    .DEPTH   (4),
    .MAX_OUT (2),
    .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .id_ready   (id_ready),
    .flush      (flush),
    .flush_pc   (flush_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs (called just after a rising edge); s stalls the memory reply.
  task automatic set_cycle(input logic g, input logic r, input logic s, input logic f,
                           input logic [31:0] fp);
    logic [31:0] a;
    imem_gnt = g;
    id_ready = r;
    flush    = f;
    flush_pc = fp;
    if (!s && mq.size() > 0) begin
      a = mq.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = {16'hC0DE, a[15:0]};
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
  endtask

  task automatic end_cycle();
    @(negedge clk);
    if (!reset && imem_req && imem_gnt) mq.push_back(imem_addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    @(posedge clk); #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, NOP);
    reset = 1'b0;

    // Streaming fetch
    set_cycle(1, 1, 0, 0, 0); chk("c0_req", imem_req, 1); chk("c0_addr", imem_addr, 32'h0);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c1_addr", imem_addr, 32'h4); chk("c1_valid", if_valid, 0);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c2_valid", if_valid, 1); chk("c2_pc", if_pc, 32'h0);
    chk("c2_instr", if_instr, 32'hC0DE_0000);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c3_pc", if_pc, 32'h4); chk("c3_instr", if_instr, 32'hC0DE_0004);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c4_pc", if_pc, 32'h8); chk("c4_addr", imem_addr, 32'h10);
    end_cycle();

    // Back-pressure fills the queue to exactly four entries
    set_cycle(1, 0, 0, 0, 0); end_cycle();
    set_cycle(1, 0, 0, 0, 0); end_cycle();
    set_cycle(1, 0, 0, 0, 0); chk("c7_req", imem_req, 0); end_cycle();
    set_cycle(1, 0, 0, 0, 0); chk("c8_req", imem_req, 0); chk("c8_pc", if_pc, 32'hC); end_cycle();
    set_cycle(1, 0, 0, 0, 0); chk("c9_req", imem_req, 0); end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c10_pc", if_pc, 32'hC); chk("c10_req", imem_req, 0);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c11_pc", if_pc, 32'h10); chk("c11_req", imem_req, 1);
    chk("c11_addr", imem_addr, 32'h1C);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c12_pc", if_pc, 32'h14); end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c13_pc", if_pc, 32'h18); end_cycle();

    // Grant withheld: request and address held, queue drains to NOP
    set_cycle(0, 1, 0, 0, 0); chk("c14_pc", if_pc, 32'h1C); chk("c14_instr", if_instr, 32'hC0DE_001C);
    end_cycle();
    set_cycle(0, 1, 0, 0, 0); chk("c15_pc", if_pc, 32'h20); chk("c15_addr", imem_addr, 32'h28);
    end_cycle();
    set_cycle(0, 1, 0, 0, 0); chk("c16_pc", if_pc, 32'h24); chk("c16_addr", imem_addr, 32'h28);
    end_cycle();
    set_cycle(0, 1, 0, 0, 0); chk("c17_valid", if_valid, 0); chk("c17_instr", if_instr, NOP);
    chk("c17_req", imem_req, 1); chk("c17_addr", imem_addr, 32'h28);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c18_addr", imem_addr, 32'h28); end_cycle();
    set_cycle(1, 1, 0, 0, 0); end_cycle();

    // Flush with two requests outstanding
    set_cycle(1, 0, 1, 0, 0); chk("c20_pc", if_pc, 32'h28); chk("c20_addr", imem_addr, 32'h30);
    end_cycle();
    set_cycle(1, 0, 1, 1, 32'h100); chk("c21_req", imem_req, 0); chk("c21_valid", if_valid, 1);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c22_valid", if_valid, 0); chk("c22_req", imem_req, 0);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c23_valid", if_valid, 0); chk("c23_req", imem_req, 1);
    chk("c23_addr", imem_addr, 32'h100);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c24_valid", if_valid, 0); end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c25_pc", if_pc, 32'h100); chk("c25_instr", if_instr, 32'hC0DE_0100);
    end_cycle();

    // Flush coincident with a response and a pop
    set_cycle(1, 0, 1, 0, 0); chk("c26_pc", if_pc, 32'h104); end_cycle();
    set_cycle(1, 1, 0, 1, 32'h200); chk("c27_req", imem_req, 0); end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c28_valid", if_valid, 0); chk("c28_addr", imem_addr, 32'h200);
    chk("c28_req", imem_req, 1);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("c29_valid", if_valid, 0); end_cycle();
    set_cycle(1, 0, 0, 0, 0); chk("c30_pc", if_pc, 32'h200); chk("c30_instr", if_instr, 32'hC0DE_0200);
    end_cycle();
    set_cycle(1, 0, 0, 0, 0); end_cycle();

    // Reset mid-stream with three entries queued
    set_cycle(1, 0, 0, 0, 0); chk("c32_req", imem_req, 0); chk("c32_valid", if_valid, 1);
    chk("c32_pc", if_pc, 32'h200);
    reset = 1'b1;
    mq.delete();
    imem_rvalid = 1'b0;
    #1;
    chk("mrst_valid", if_valid, 0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_pc", if_pc, 32'h0);
    chk("mrst_instr", if_instr, NOP);
    chk("mrst_req", imem_req, 0);
    end_cycle();
    reset = 1'b0;
    set_cycle(1, 1, 0, 0, 0); chk("post_req", imem_req, 1); chk("post_addr0", imem_addr, 32'h0);
    end_cycle();
    set_cycle(1, 1, 0, 0, 0); chk("post_addr4", imem_addr, 32'h4); end_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
